// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter for the common data bus.
// Each requester (0=ALU, 1=LSB load, 2=branch unit) owns a one-entry holding
// slot. Pending slots are granted one per cycle in round-robin order, and the
// granted slot's contents are registered onto the CDB outputs. A slot being
// granted can take a new result on the same edge, so a single requester can
// stream one result per cycle when uncontended.
module wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*IDX_W-1:0]  req_rob_idx,
  input  logic [N_REQ*DATA_W-1:0] req_value,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [IDX_W-1:0]        cdb_rob_idx,
  output logic [DATA_W-1:0]       cdb_value,
  output logic [1:0]              cdb_src,
  output logic [15:0]             grant_cnt
);

  // Pointer wide enough to name any requester; at least one bit.
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  // Block may make progress this cycle: out of reset, not paused, not flushing.
  logic              advance;

  // Slot state gathered from the per-requester slot instances.
  logic [N_REQ-1:0]  pending;
  logic [IDX_W-1:0]  slot_idx [N_REQ];
  logic [DATA_W-1:0] slot_val [N_REQ];

  // Arbitration results.
  logic [N_REQ-1:0]  hi_oh;
  logic [N_REQ-1:0]  lo_oh;
  logic              hi_found;
  logic [N_REQ-1:0]  grant_raw;
  logic [N_REQ-1:0]  grant;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [N_REQ-1:0]  accept;

  // Granted slot contents, muxed from the one-hot grant.
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_val;

  // Registered state.
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [IDX_W-1:0]  cdb_rob_idx_q, cdb_rob_idx_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic [1:0]        cdb_src_q, cdb_src_d;
  logic [15:0]       grant_cnt_q, grant_cnt_d;

  assign advance   = rst_in & rdy_in & ~clear;
  assign grant     = advance ? grant_raw : '0;
  assign grant_any = |grant;

  // A slot accepts when empty or when it is being drained this same edge.
  assign req_ready = {N_REQ{advance}} & (~pending | grant);
  assign accept    = req_valid & req_ready;

  // Per-requester holding slot: refill wins over drain on the same edge.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    logic              pend_q, pend_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] val_q, val_d;

    // Next slot contents: flush, fill, drain or hold.
    always_comb begin
      pend_d = pend_q;
      idx_d  = idx_q;
      val_d  = val_q;
      if (rdy_in) begin
        if (clear) begin
          pend_d = 1'b0;
        end else if (accept[gi]) begin
          pend_d = 1'b1;
          idx_d  = req_rob_idx[gi*IDX_W +: IDX_W];
          val_d  = req_value[gi*DATA_W +: DATA_W];
        end else if (grant[gi]) begin
          pend_d = 1'b0;
        end
      end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
      if (!rst_in) begin
        pend_q <= 1'b0;
        idx_q  <= '0;
        val_q  <= '0;
      end else begin
        pend_q <= pend_d;
        idx_q  <= idx_d;
        val_q  <= val_d;
      end
    end

    assign pending[gi]  = pend_q;
    assign slot_idx[gi] = idx_q;
    assign slot_val[gi] = val_q;
  end

  // Round-robin pick: lowest pending slot at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_oh    = '0;
    lo_oh    = '0;
    hi_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lo_oh    = '0;
        lo_oh[i] = 1'b1;
        if (i >= int'(rr_ptr_q)) begin
          hi_oh    = '0;
          hi_oh[i] = 1'b1;
          hi_found = 1'b1;
        end
      end
    end
    grant_raw = hi_found ? hi_oh : lo_oh;
  end

  // Encode the one-hot grant and mux out the granted slot's contents.
  always_comb begin
    grant_idx = '0;
    sel_idx   = '0;
    sel_val   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_raw[i]) begin
        grant_idx = PTR_W'(i);
        sel_idx   = sel_idx | slot_idx[i];
        sel_val   = sel_val | slot_val[i];
      end
    end
  end

  // Next CDB, pointer and counter state; rdy_in low holds everything.
  always_comb begin
    cdb_valid_d   = cdb_valid_q;
    cdb_rob_idx_d = cdb_rob_idx_q;
    cdb_value_d   = cdb_value_q;
    cdb_src_d     = cdb_src_q;
    rr_ptr_d      = rr_ptr_q;
    grant_cnt_d   = grant_cnt_q;
    if (rdy_in) begin
      if (clear) begin
        // Flush kills the in-flight broadcast and restarts arbitration at 0.
        cdb_valid_d = 1'b0;
        rr_ptr_d    = '0;
      end else if (grant_any) begin
        cdb_valid_d   = 1'b1;
        cdb_rob_idx_d = sel_idx;
        cdb_value_d   = sel_val;
        cdb_src_d     = 2'(grant_idx);
        rr_ptr_d      = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
        if (grant_cnt_q != 16'hFFFF) begin
          grant_cnt_d = grant_cnt_q + 16'd1;
        end
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  // Output and arbitration registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rr_ptr_q      <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_rob_idx_q <= '0;
      cdb_value_q   <= '0;
      cdb_src_q     <= 2'd0;
      grant_cnt_q   <= 16'd0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_idx_q <= cdb_rob_idx_d;
      cdb_value_q   <= cdb_value_d;
      cdb_src_q     <= cdb_src_d;
      grant_cnt_q   <= grant_cnt_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_idx = cdb_rob_idx_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_src     = cdb_src_q;
  assign grant_cnt   = grant_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven directed vectors for wb_arbiter, followed by a
// hand-written full-contention / drain sequence.
module tb_wb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic [2:0]  req_valid;
  logic [11:0] req_rob_idx;
  logic [95:0] req_value;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_idx;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;
  logic [15:0] grant_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  wb_arbiter #(.N_REQ(3), .IDX_W(4), .DATA_W(32)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_rob_idx (req_rob_idx),
    .req_value   (req_value),
    .req_ready   (req_ready),
    .cdb_valid   (cdb_valid),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_value   (cdb_value),
    .cdb_src     (cdb_src),
    .grant_cnt   (grant_cnt)
  );

  // One cycle: inputs, expected combinational ready, expected outputs after the edge.
  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        clr;
    logic [2:0]  vld;
    logic [3:0]  i0, i1, i2;
    logic [31:0] v0, v1, v2;
    logic [2:0]  e_ready;
    logic        e_valid;
    logic        chk_data;
    logic [3:0]  e_idx;
    logic [31:0] e_val;
    logic [1:0]  e_src;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst_n, input logic rdy, input logic clr, input logic [2:0] vld,
    input logic [3:0] i0, input logic [31:0] v0,
    input logic [3:0] i1, input logic [31:0] v1,
    input logic [3:0] i2, input logic [31:0] v2,
    input logic [2:0] e_ready, input logic e_valid, input logic chk_data,
    input logic [3:0] e_idx, input logic [31:0] e_val, input logic [1:0] e_src,
    input logic [15:0] e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.rdy = rdy; v.clr = clr; v.vld = vld;
    v.i0 = i0; v.i1 = i1; v.i2 = i2;
    v.v0 = v0; v.v1 = v1; v.v2 = v2;
    v.e_ready = e_ready; v.e_valid = e_valid; v.chk_data = chk_data;
    v.e_idx = e_idx; v.e_val = e_val; v.e_src = e_src; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int vn, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h exp=%h", nm, vn, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_in      = v.rst_n;
    rdy_in      = v.rdy;
    clear       = v.clr;
    req_valid   = v.vld;
    req_rob_idx = {v.i2, v.i1, v.i0};
    req_value   = {v.v2, v.v1, v.v0};
  endtask

  logic [3:0]  m_idx [3];
  logic [31:0] m_val [3];
  logic [3:0]  o_idx [3];
  logic [31:0] o_val [3];
  logic [2:0]  exp_rdy;
  logic [15:0] exp_cnt;
  int          s;

  initial begin
    // reset (twice: second with rdy low, clear high and junk requests)
    tbl.push_back(mk(0,1,0,3'b000, 0,0, 0,0, 0,0, 3'b000, 0,1, 0,0,0, 0));
    tbl.push_back(mk(0,0,1,3'b111, 1,32'h11, 2,32'h22, 3,32'h33, 3'b000, 0,1, 0,0,0, 0));
    // single ALU result idx 5 / 0x1234: slot fill, then broadcast, then idle
    tbl.push_back(mk(1,1,0,3'b001, 5,32'h1234, 0,0, 0,0, 3'b111, 0,1, 0,0,0, 0));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,1, 5,32'h1234,0, 1));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0, 0,0,0, 1));
    // clear with requests present: requests ignored, pointer back to 0
    tbl.push_back(mk(1,1,1,3'b111, 7,32'hDEAD, 7,32'hDEAD, 7,32'hDEAD, 3'b000, 0,0, 0,0,0, 1));
    // all three at once, idx 1,2,3 -> src 0,1,2 on consecutive cycles
    tbl.push_back(mk(1,1,0,3'b111, 1,32'hA1, 2,32'hA2, 3,32'hA3, 3'b111, 0,0, 0,0,0, 1));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b001, 1,1, 1,32'hA1,0, 2));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b011, 1,1, 2,32'hA2,1, 3));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,1, 3,32'hA3,2, 4));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0, 0,0,0, 4));
    // ALU streams 4,5,6 against LSB idx 9: order 4,9,5,6; ALU holds 6 for one
    // cycle while its slot (holding 5) waits behind the LSB grant
    tbl.push_back(mk(1,1,0,3'b011, 4,32'hB4, 9,32'hB9, 0,0, 3'b111, 0,0, 0,0,0, 4));
    tbl.push_back(mk(1,1,0,3'b001, 5,32'hB5, 0,0, 0,0, 3'b101, 1,1, 4,32'hB4,0, 5));
    tbl.push_back(mk(1,1,0,3'b001, 6,32'hB6, 0,0, 0,0, 3'b110, 1,1, 9,32'hB9,1, 6));
    tbl.push_back(mk(1,1,0,3'b001, 6,32'hB6, 0,0, 0,0, 3'b111, 1,1, 5,32'hB5,0, 7));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,1, 6,32'hB6,0, 8));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0, 0,0,0, 8));
    // two slots pending, clear pulse: nothing broadcast, count unchanged
    tbl.push_back(mk(1,1,0,3'b101, 7,32'hC7, 0,0, 8,32'hC8, 3'b111, 0,0, 0,0,0, 8));
    tbl.push_back(mk(1,1,1,3'b000, 0,0, 0,0, 0,0, 3'b000, 0,0, 0,0,0, 8));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0, 0,0,0, 8));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0, 0,0,0, 8));
    // rdy_in low 3 cycles with cdb_valid=1 and LSB slot pending
    tbl.push_back(mk(1,1,0,3'b011, 10,32'hD00A, 11,32'hD00B, 0,0, 3'b111, 0,0, 0,0,0, 8));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b101, 1,1, 10,32'hD00A,0, 9));
    tbl.push_back(mk(1,0,0,3'b111, 15,32'hEEEE, 15,32'hEEEE, 15,32'hEEEE, 3'b000, 1,1, 10,32'hD00A,0, 9));
    tbl.push_back(mk(1,0,0,3'b111, 15,32'hEEEE, 15,32'hEEEE, 15,32'hEEEE, 3'b000, 1,1, 10,32'hD00A,0, 9));
    tbl.push_back(mk(1,0,0,3'b111, 15,32'hEEEE, 15,32'hEEEE, 15,32'hEEEE, 3'b000, 1,1, 10,32'hD00A,0, 9));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,1, 11,32'hD00B,1, 10));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0, 0,0,0, 10));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0, 0,0,0, 10));
    // reset mid-operation with all slots pending and a broadcast in flight
    tbl.push_back(mk(1,1,0,3'b111, 12,32'hF00C, 13,32'hF00D, 14,32'hF00E, 3'b111, 0,0, 0,0,0, 10));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b100, 1,1, 14,32'hF00E,2, 11));
    tbl.push_back(mk(0,1,0,3'b000, 0,0, 0,0, 0,0, 3'b000, 0,1, 0,0,0, 0));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,1, 0,0,0, 0));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0, 0,0,0, 0));
    // clear while paused is frozen out; the pending entry still broadcasts
    tbl.push_back(mk(1,1,0,3'b100, 0,0, 0,0, 15,32'h0F0F, 3'b111, 0,0, 0,0,0, 0));
    tbl.push_back(mk(1,0,1,3'b000, 0,0, 0,0, 0,0, 3'b000, 0,1, 0,0,0, 0));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,1, 15,32'h0F0F,2, 1));
    tbl.push_back(mk(1,1,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0, 0,0,0, 1));

    @(posedge clk_in);
    #1;
    for (int k = 0; k < tbl.size(); k++) begin
      vec_t v;
      v = tbl[k];
      drive(v);
      #1;
      chk("req_ready", k, 32'(req_ready), 32'(v.e_ready));
      @(posedge clk_in);
      #1;
      chk("cdb_valid", k, 32'(cdb_valid), 32'(v.e_valid));
      if (v.chk_data) begin
        chk("cdb_rob_idx", k, 32'(cdb_rob_idx), 32'(v.e_idx));
        chk("cdb_value", k, cdb_value, v.e_val);
        chk("cdb_src", k, 32'(cdb_src), 32'(v.e_src));
      end
      chk("grant_cnt", k, 32'(grant_cnt), 32'(v.e_cnt));
      $display("vec %0d: ready=%b cdb_valid=%b idx=%0d value=%h src=%0d cnt=%0d",
               k, req_ready, cdb_valid, cdb_rob_idx, cdb_value, cdb_src, grant_cnt);
    end

    // Full contention for 9 cycles, then drain: one broadcast per cycle in
    // strict rotation 0,1,2,..., each granted slot refilled on the same edge.
    exp_cnt = 16'd1;
    for (int r = 0; r < 3; r++) begin
      m_idx[r] = '0;
      m_val[r] = '0;
    end
    for (int c = 0; c < 13; c++) begin
      rst_in    = 1'b1;
      rdy_in    = 1'b1;
      clear     = 1'b0;
      req_valid = (c < 9) ? 3'b111 : 3'b000;
      for (int r = 0; r < 3; r++) begin
        o_idx[r] = 4'((c * 3 + r) % 16);
        o_val[r] = 32'hC000_0000 | 32'(r << 16) | 32'(c);
      end
      req_rob_idx = {o_idx[2], o_idx[1], o_idx[0]};
      req_value   = {o_val[2], o_val[1], o_val[0]};
      if (c == 0)       exp_rdy = 3'b111;
      else if (c < 9)   exp_rdy = 3'b001 << ((c - 1) % 3);
      else if (c == 9)  exp_rdy = 3'b100;
      else if (c == 10) exp_rdy = 3'b101;
      else              exp_rdy = 3'b111;
      #1;
      chk("seq_ready", c, 32'(req_ready), 32'(exp_rdy));
      @(posedge clk_in);
      #1;
      if (c >= 1 && c <= 11) begin
        s = (c - 1) % 3;
        exp_cnt = exp_cnt + 16'd1;
        chk("seq_valid", c, 32'(cdb_valid), 32'd1);
        chk("seq_idx", c, 32'(cdb_rob_idx), 32'(m_idx[s]));
        chk("seq_value", c, cdb_value, m_val[s]);
        chk("seq_src", c, 32'(cdb_src), 32'(s));
      end else begin
        chk("seq_valid", c, 32'(cdb_valid), 32'd0);
      end
      chk("seq_cnt", c, 32'(grant_cnt), 32'(exp_cnt));
      $display("seq %0d: ready=%b cdb_valid=%b idx=%0d value=%h src=%0d cnt=%0d",
               c, req_ready, cdb_valid, cdb_rob_idx, cdb_value, cdb_src, grant_cnt);
      if (c < 9) begin
        for (int r = 0; r < 3; r++) begin
          if (exp_rdy[r]) begin
            m_idx[r] = o_idx[r];
            m_val[r] = o_val[r];
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
